// File: rtl/pam_n_encoder.sv
// PAM-N line encoder: packs 1/2/3 serial bits per symbol, optional Gray decode,
// maps to an equally spaced signed level behind a single registered valid/ready stage.
module pam_n_encoder #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int PAM2_STEP         = 168,
  parameter int PAM4_STEP         = 56,
  parameter int PAM8_STEP         = 24,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [1:0]                          mode,
  input  logic                                gray_en,
  input  logic                                bit_in,
  input  logic                                bit_in_valid,
  output logic                                bit_in_ready,
  output logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_out,
  output logic                                voltage_level_out_valid,
  input  logic                                voltage_level_out_ready,
  output logic [COUNT_WIDTH-1:0]              symbol_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and held data stays stable while valid && !ready.

  localparam int LW = SIGNAL_RESOLUTION + 4;
  localparam logic signed [LW-1:0] LEVEL_MAX = LW'((2 ** (SIGNAL_RESOLUTION - 1)) - 1);
  localparam logic signed [LW-1:0] LEVEL_MIN = LW'(-(2 ** (SIGNAL_RESOLUTION - 1)));

  logic [1:0] acc;
  logic [1:0] bit_cnt;
  logic [1:0] cfg_mode;
  logic       cfg_gray;

  logic [1:0] eff_mode;
  logic       eff_gray;
  logic [1:0] bits_m1;
  logic [2:0] levels_m1;
  logic [2:0] gray_code;
  logic [2:0] idx;
  int         step;
  logic signed [LW-1:0] odd_w;
  logic signed [LW-1:0] half_w;
  logic signed [LW-1:0] prod_w;
  logic [SIGNAL_RESOLUTION-1:0] level_sat;
  logic accept;
  logic sym_done;

  assign bit_in_ready = !voltage_level_out_valid || voltage_level_out_ready;
  assign accept       = bit_in_valid && bit_in_ready;

  always_comb begin
    // The first bit of a symbol uses the live configuration, later bits the latched one.
    eff_mode  = (bit_cnt == 2'd0) ? mode : cfg_mode;
    eff_gray  = (bit_cnt == 2'd0) ? gray_en : cfg_gray;
    bits_m1   = 2'd1;
    levels_m1 = 3'd3;
    step      = PAM4_STEP;
    gray_code = {1'b0, acc[0], bit_in};
    case (eff_mode)
      2'b00: begin
        bits_m1   = 2'd0;
        levels_m1 = 3'd1;
        step      = PAM2_STEP;
        gray_code = {2'b00, bit_in};
      end
      2'b10: begin
        bits_m1   = 2'd2;
        levels_m1 = 3'd7;
        step      = PAM8_STEP;
        gray_code = {acc, bit_in};
      end
      default: ;
    endcase

    // Leading zeros are transparent to Gray-to-binary, so one 3-bit path serves all modes.
    idx = gray_code;
    if (eff_gray) begin
      idx[2] = gray_code[2];
      idx[1] = idx[2] ^ gray_code[1];
      idx[0] = idx[1] ^ gray_code[0];
    end

    odd_w  = $signed(LW'({idx, 1'b0})) - $signed(LW'(levels_m1));
    half_w = LW'(step / 2);
    prod_w = odd_w * half_w;

    if (prod_w > LEVEL_MAX)      level_sat = LEVEL_MAX[SIGNAL_RESOLUTION-1:0];
    else if (prod_w < LEVEL_MIN) level_sat = LEVEL_MIN[SIGNAL_RESOLUTION-1:0];
    else                         level_sat = prod_w[SIGNAL_RESOLUTION-1:0];

    sym_done = accept && (bit_cnt == bits_m1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc                     <= '0;
      bit_cnt                 <= '0;
      cfg_mode                <= 2'b01;
      cfg_gray                <= 1'b0;
      voltage_level_out       <= '0;
      voltage_level_out_valid <= 1'b0;
      symbol_count            <= '0;
    end else begin
      if (accept && bit_cnt == 2'd0) begin
        cfg_mode <= mode;
        cfg_gray <= gray_en;
      end
      if (sym_done) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else if (accept) begin
        acc     <= {acc[0], bit_in};
        bit_cnt <= bit_cnt + 2'd1;
      end

      if (sym_done) begin
        voltage_level_out       <= $signed(level_sat);
        voltage_level_out_valid <= 1'b1;
      end else if (voltage_level_out_valid && voltage_level_out_ready) begin
        voltage_level_out_valid <= 1'b0;
      end

      if (voltage_level_out_valid && voltage_level_out_ready)
        symbol_count <= symbol_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pam_n_encoder.sv
// Directed bench for pam_n_encoder: hand-computed levels go into a scoreboard queue
// that an output monitor drains on every output transfer.
module tb_pam_n_encoder;

  localparam int R  = 8;
  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [1:0]    mode;
  logic          gray_en;
  logic          bit_in;
  logic          bit_in_valid;
  logic          bit_in_ready;
  logic [R-1:0]  voltage_level_out;
  logic          voltage_level_out_valid;
  logic          voltage_level_out_ready;
  logic [CW-1:0] symbol_count;

  logic [R-1:0]  exp_q[$];
  logic [CW-1:0] exp_count;
  int            n_checks = 0;
  int            n_fail   = 0;

  pam_n_encoder #(
    .SIGNAL_RESOLUTION(R),
    .PAM2_STEP(168),
    .PAM4_STEP(56),
    .PAM8_STEP(24),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .mode(mode),
    .gray_en(gray_en),
    .bit_in(bit_in),
    .bit_in_valid(bit_in_valid),
    .bit_in_ready(bit_in_ready),
    .voltage_level_out(voltage_level_out),
    .voltage_level_out_valid(voltage_level_out_valid),
    .voltage_level_out_ready(voltage_level_out_ready),
    .symbol_count(symbol_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [R-1:0] lv(input int v);
    return R'(v);
  endfunction

  // scoreboard: drain one expected level per output transfer
  always @(negedge clk) begin
    if (!rstn) begin
      exp_count = '0;
    end else if (voltage_level_out_valid && voltage_level_out_ready) begin
      exp_count = exp_count + 1'b1;
      if (exp_q.size() == 0)
        check_eq("unexpected_symbol", 32'(voltage_level_out), 32'hffff_ffff);
      else
        check_eq("level", 32'(voltage_level_out), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks; inputs change 1 time unit after the rising edge
  task automatic send_bit(input logic b);
    bit ok;
    int guard;
    bit_in       = b;
    bit_in_valid = 1'b1;
    ok           = 1'b0;
    guard        = 0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = bit_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) check_eq("accept_timeout", 32'(bit_in_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    bit_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_of_group(input string tag, input logic [CW-1:0] count);
    idle(3);
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_count"}, 32'(symbol_count), 32'(count));
    check_eq({tag, "_count_model"}, 32'(symbol_count), 32'(exp_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    mode = 2'b01;
    gray_en = 1'b0;
    bit_in = 1'b0;
    bit_in_valid = 1'b0;
    voltage_level_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_level", 32'(voltage_level_out), 32'd0);
    check_eq("rst_valid", 32'(voltage_level_out_valid), 32'd0);
    check_eq("rst_count", 32'(symbol_count), 32'd0);
    check_eq("rst_ready", 32'(bit_in_ready), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // PAM4 binary, full sweep, one-cycle valid pulses
    mode = 2'b01;
    exp_q.push_back(lv(-84)); exp_q.push_back(lv(-28));
    exp_q.push_back(lv(28));  exp_q.push_back(lv(84));
    send_bit(0); send_bit(0);
    check_eq("t1_valid_after_2nd", 32'(voltage_level_out_valid), 32'd1);
    check_eq("t1_first_level", 32'(voltage_level_out), 32'(lv(-84)));
    send_bit(0);
    check_eq("t1_valid_pulse", 32'(voltage_level_out_valid), 32'd0);
    send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    end_of_group("t1", 4'd4);

    // PAM4 Gray
    gray_en = 1'b1;
    exp_q.push_back(lv(28)); exp_q.push_back(lv(84));
    send_bit(1); send_bit(1); send_bit(1); send_bit(0);
    end_of_group("t2", 4'd6);
    gray_en = 1'b0;

    // PAM8, then PAM2 back-to-back
    mode = 2'b10;
    exp_q.push_back(lv(36)); exp_q.push_back(lv(-84)); exp_q.push_back(lv(84));
    send_bit(1); send_bit(0); send_bit(1);
    send_bit(0); send_bit(0); send_bit(0);
    send_bit(1); send_bit(1); send_bit(1);
    mode = 2'b00;
    exp_q.push_back(lv(-84)); exp_q.push_back(lv(84));
    send_bit(0);
    check_eq("t3_pam2_first", 32'(voltage_level_out), 32'(lv(-84)));
    send_bit(1);
    check_eq("t3_b2b_valid", 32'(voltage_level_out_valid), 32'd1);
    check_eq("t3_b2b_level", 32'(voltage_level_out), 32'(lv(84)));
    end_of_group("t3", 4'd11);

    // backpressure: first level held, input stalled, nothing lost
    voltage_level_out_ready = 1'b0;
    exp_q.push_back(lv(84)); exp_q.push_back(lv(-84)); exp_q.push_back(lv(84));
    send_bit(1);
    bit_in = 1'b0;
    bit_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(voltage_level_out_valid), 32'd1);
      check_eq("bp_level", 32'(voltage_level_out), 32'(lv(84)));
      check_eq("bp_in_ready", 32'(bit_in_ready), 32'd0);
      check_eq("bp_count", 32'(symbol_count), 32'd11);
    end
    @(posedge clk);
    #1 voltage_level_out_ready = 1'b1;
    send_bit(0); send_bit(1);
    end_of_group("bp", 4'd14);

    // mode change mid-symbol takes effect at the next symbol; count wraps
    mode = 2'b01;
    exp_q.push_back(lv(28)); exp_q.push_back(lv(60));
    send_bit(1);
    mode = 2'b10;
    send_bit(0);
    check_eq("mc_pam4_level", 32'(voltage_level_out), 32'(lv(28)));
    send_bit(1); send_bit(1); send_bit(0);
    end_of_group("mc", 4'd0);

    // reset mid-symbol discards partial bits
    mode = 2'b00;
    exp_q.push_back(lv(-84));
    send_bit(0);
    end_of_group("pre_rst", 4'd1);
    mode = 2'b10;
    send_bit(1); send_bit(1);
    bit_in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_level", 32'(voltage_level_out), 32'd0);
    check_eq("mid_rst_valid", 32'(voltage_level_out_valid), 32'd0);
    check_eq("mid_rst_count", 32'(symbol_count), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.push_back(lv(-12));
    send_bit(0); send_bit(1); send_bit(1);
    end_of_group("post_rst", 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
